// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: default width and the
// binary-to-reflected-Gray conversion used by the datapath and the bench.
package gray_pkg;

  localparam int GRAY_WIDTH = 3;

  // Reflected-binary conversion on a 32-bit container; callers cast to their width.
  function automatic logic [31:0] bin2gray_f(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_bin2gray.sv
// Purely combinational binary-to-Gray converter, parameterised by WIDTH.
module bin2gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = WIDTH'(bin2gray_f(32'(bin_i)));

endmodule

// File: rtl/gray.sv
// Enable-gated Gray-code counter with a sticky wrap flag. The count is kept in
// binary and converted combinationally, so consecutive codes differ in one bit.
module gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic             ovf_q, ovf_d;

  // Next state: increment when enabled; the all-ones count is the wrap point.
  always_comb begin
    bin_d = bin_q;
    ovf_d = ovf_q;
    if (En) begin
      bin_d = bin_q + WIDTH'(1'b1);
      if (&bin_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      ovf_q <= ovf_d;
    end
  end

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin_i  (bin_q),
    .gray_o (Output)
  );

  assign Overflow = ovf_q;

endmodule

// File: tb/tb_gray.sv
// Self-checking bench for the Gray-code counter: directed scenarios plus a
// randomized run against a table-driven reference model.
module tb_gray;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] Output;
  logic       Overflow;

  int checks;
  int errors;

  // Reference model: code sequence listed explicitly, count as an index into it.
  logic [2:0] gtab [8];
  int         m_cnt;
  bit         m_ovf;
  logic [2:0] prev_out;

  gray #(.WIDTH(3)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Output   (Output),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Apply inputs, take one rising edge, sample 1 time unit later, advance model.
  task automatic step(input bit en, input bit rst);
    En    = en;
    Reset = rst;
    @(posedge Clk);
    #1;
    if (rst) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (en) begin
      if (m_cnt == 7) m_ovf = 1'b1;
      m_cnt = (m_cnt + 1) % 8;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (Output !== 3'b000 || Overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_assert[%0d]: got out=%b ovf=%b, want out=000 ovf=0", i, Output, Overflow);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (Output !== 3'b000 || Overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got out=%b ovf=%b, want out=000 ovf=0", i, Output, Overflow);
      end
    end
  endtask

  task automatic test_count_wrap();
    logic [2:0] seq [8];
    seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    for (int lap = 0; lap < 2; lap++) begin
      for (int i = 0; i < 8; i++) begin
        logic exp_ovf;
        exp_ovf = (lap == 1) || (i == 7);
        step(1'b1, 1'b0);
        checks++;
        if (Output !== seq[i] || Overflow !== exp_ovf) begin
          errors++;
          $display("FAIL count_lap%0d[%0d]: got out=%b ovf=%b, want out=%b ovf=%b",
                   lap, i, Output, Overflow, seq[i], exp_ovf);
        end
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    checks++;
    if (Output !== 3'b010) begin
      errors++;
      $display("FAIL hold_setup: got out=%b, want 010", Output);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (Output !== 3'b010 || Overflow !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: got out=%b ovf=%b, want out=010 ovf=1", i, Output, Overflow);
      end
    end
  endtask

  task automatic test_reset_priority();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (Output !== 3'b111 || Overflow !== 1'b1) begin
      errors++;
      $display("FAIL prio_setup: got out=%b ovf=%b, want out=111 ovf=1", Output, Overflow);
    end
    step(1'b1, 1'b1);
    checks++;
    if (Output !== 3'b000 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL prio_reset: got out=%b ovf=%b, want out=000 ovf=0", Output, Overflow);
    end
    step(1'b1, 1'b0);
    checks++;
    if (Output !== 3'b001 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL prio_resume: got out=%b ovf=%b, want out=001 ovf=0", Output, Overflow);
    end
  endtask

  task automatic test_random();
    prev_out = Output;
    for (int i = 0; i < 300; i++) begin
      bit en, rst;
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      step(en, rst);
      checks++;
      if (Output !== gtab[m_cnt] || Overflow !== m_ovf) begin
        errors++;
        $display("FAIL random[%0d]: got out=%b ovf=%b, want out=%b ovf=%b",
                 i, Output, Overflow, gtab[m_cnt], m_ovf);
      end
      if (!rst && Output !== prev_out) begin
        checks++;
        if ($countones(Output ^ prev_out) != 1) begin
          errors++;
          $display("FAIL random_onebit[%0d]: got %b -> %b, want single-bit change",
                   i, prev_out, Output);
        end
      end
      prev_out = Output;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    gtab   = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    m_cnt  = 0;
    m_ovf  = 1'b0;
    Reset  = 1'b1;
    En     = 1'b0;

    test_reset();
    test_count_wrap();
    test_hold();
    test_reset_priority();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
